saph_fpu_client: RTL and testbench

// Core-side initiator for one FPU port. It accepts FP commands from the issue stage and tags each one with a reorder-buffer slot.
// It drives requests into the FPU port, which is served by the saph_fpu mux/demux fabric.
// FPU responses may return out of order from different add/mul/div units; this block collects them and hands results to writeback strictly in issue order.

---
 rtl/saph_fpu_client.sv | 126 ++++++++++++
 tb/tb_saph_fpu_client.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saph_fpu_client.sv
// Core-side FPU port initiator with a small reorder buffer.
// Requests are tagged by ROB slot; results retire to writeback in issue order.
module saph_fpu_client #(
  parameter  int depth  = 4,
  parameter  int data_w = 32,
  parameter  int op_w   = 4,
  parameter  int dst_w  = 5,
  localparam int tw     = $clog2(depth)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [op_w-1:0]   cmd_op,
  input  logic [data_w-1:0] cmd_a,
  input  logic [data_w-1:0] cmd_b,
  input  logic [dst_w-1:0]  cmd_dst,
  output logic              fpi_req_valid,
  input  logic              fpi_req_ready,
  output logic [op_w-1:0]   fpi_req_op,
  output logic [data_w-1:0] fpi_req_a,
  output logic [data_w-1:0] fpi_req_b,
  output logic [tw-1:0]     fpi_req_tag,
  input  logic              fpi_resp_valid,
  input  logic [tw-1:0]     fpi_resp_tag,
  input  logic [data_w-1:0] fpi_resp_data,
  input  logic [4:0]        fpi_resp_exc,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [dst_w-1:0]  wb_dst,
  output logic [data_w-1:0] wb_data,
  output logic [4:0]        wb_exc,
  output logic              busy,
  output logic              err_tag
);

  localparam logic [1:0] st_inv  = 2'd0;
  localparam logic [1:0] st_pend = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  localparam logic [tw:0]   cnt_max = (tw+1)'(depth);
  localparam logic [tw:0]   cnt_one = (tw+1)'(1);
  localparam logic [tw-1:0] ptr_one = tw'(1);

  logic [1:0]        st    [depth];
  logic [dst_w-1:0]  dst_q [depth];
  logic [data_w-1:0] data_q[depth];
  logic [4:0]        exc_q [depth];

  logic [tw-1:0] head;
  logic [tw-1:0] tail;
  logic [tw:0]   count;

  logic acc;
  logic ret;
  logic resp_ok;
  logic resp_bad;

  assign cmd_ready = (count < cnt_max) &&
                     (!fpi_req_valid || fpi_req_ready);
  assign acc       = cmd_valid && cmd_ready;

  assign wb_valid  = (st[head] == st_done);
  assign wb_dst    = dst_q[head];
  assign wb_data   = data_q[head];
  assign wb_exc    = exc_q[head];
  assign ret       = wb_valid && wb_ready;

  // The slot being allocated is still invalid this cycle, so a
  // response naming it falls into resp_bad without extra logic.
  assign resp_ok   = fpi_resp_valid && (st[fpi_resp_tag] == st_pend);
  assign resp_bad  = fpi_resp_valid && (st[fpi_resp_tag] != st_pend);

  assign busy      = (count != '0) || fpi_req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) begin
        st[i] <= st_inv;
      end
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      fpi_req_valid <= 1'b0;
      err_tag       <= 1'b0;
    end else begin
      if (acc) begin
        st[tail]    <= st_pend;
        dst_q[tail] <= cmd_dst;
        tail        <= tail + ptr_one;
      end

      if (resp_ok) begin
        st[fpi_resp_tag]     <= st_done;
        data_q[fpi_resp_tag] <= fpi_resp_data;
        exc_q[fpi_resp_tag]  <= fpi_resp_exc;
      end

      if (resp_bad) begin
        err_tag <= 1'b1;
      end

      if (ret) begin
        st[head] <= st_inv;
        head     <= head + ptr_one;
      end

      unique case (1'b1)
        acc && !ret: count <= count + cnt_one;
        ret && !acc: count <= count - cnt_one;
        default:     ;
      endcase

      if (acc) begin
        fpi_req_valid <= 1'b1;
        fpi_req_op    <= cmd_op;
        fpi_req_a     <= cmd_a;
        fpi_req_b     <= cmd_b;
        fpi_req_tag   <= tail;
      end else if (fpi_req_ready) begin
        fpi_req_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_saph_fpu_client.sv
// Scoreboard bench for saph_fpu_client: directed ops, queued
// expectations, negedge monitor for request and writeback ports.
module tb_saph_fpu_client;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [4:0]  cmd_dst;
  logic        fpi_req_valid;
  logic        fpi_req_ready;
  logic [3:0]  fpi_req_op;
  logic [31:0] fpi_req_a;
  logic [31:0] fpi_req_b;
  logic [1:0]  fpi_req_tag;
  logic        fpi_resp_valid;
  logic [1:0]  fpi_resp_tag;
  logic [31:0] fpi_resp_data;
  logic [4:0]  fpi_resp_exc;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic [4:0]  wb_exc;
  logic        busy;
  logic        err_tag;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  tag;
  } req_t;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
    logic [4:0]  exc;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  req_t re;
  wb_t  we;

  int checks = 0;
  int fails  = 0;

  saph_fpu_client dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_dst(cmd_dst),
    .fpi_req_valid(fpi_req_valid),
    .fpi_req_ready(fpi_req_ready),
    .fpi_req_op(fpi_req_op), .fpi_req_a(fpi_req_a),
    .fpi_req_b(fpi_req_b), .fpi_req_tag(fpi_req_tag),
    .fpi_resp_valid(fpi_resp_valid),
    .fpi_resp_tag(fpi_resp_tag),
    .fpi_resp_data(fpi_resp_data),
    .fpi_resp_exc(fpi_resp_exc),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dst(wb_dst), .wb_data(wb_data), .wb_exc(wb_exc),
    .busy(busy), .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_q.delete();
    wb_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] dst,
                       input logic [1:0] tag,
                       input logic [31:0] res,
                       input logic [4:0] exc);
    bit ok = 0;
    req_q.push_back('{op: op, a: a, b: b, tag: tag});
    wb_q.push_back('{dst: dst, data: res, exc: exc});
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_dst   = dst;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 64'd0, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [1:0] tag,
                         input logic [31:0] data,
                         input logic [4:0] exc);
    fpi_resp_valid = 1'b1;
    fpi_resp_tag   = tag;
    fpi_resp_data  = data;
    fpi_resp_exc   = exc;
    tick();
    fpi_resp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fpi_req_valid && fpi_req_ready) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 64'd1, 64'd0);
        end else begin
          re = req_q.pop_front();
          chk("req_op", 64'(fpi_req_op), 64'(re.op));
          chk("req_a", 64'(fpi_req_a), 64'(re.a));
          chk("req_b", 64'(fpi_req_b), 64'(re.b));
          chk("req_tag", 64'(fpi_req_tag), 64'(re.tag));
        end
      end
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", 64'd1, 64'd0);
        end else begin
          we = wb_q.pop_front();
          chk("wb_dst", 64'(wb_dst), 64'(we.dst));
          chk("wb_data", 64'(wb_data), 64'(we.data));
          chk("wb_exc", 64'(wb_exc), 64'(we.exc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_dst = '0;
    fpi_req_ready = 1'b1;
    fpi_resp_valid = 1'b0;
    fpi_resp_tag = '0; fpi_resp_data = '0; fpi_resp_exc = '0;
    wb_ready = 1'b1;
    tick();
    do_reset();

    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_tag", 64'(err_tag), 64'd0);
    chk("rst_req_valid", 64'(fpi_req_valid), 64'd0);

    // single op
    tick();
    issue(4'd1, 32'h3F800000, 32'h40000000, 5'd3, 2'd0,
          32'h40400000, 5'd0);
    chk("single_req_valid", 64'(fpi_req_valid), 64'd1);
    chk("single_req_tag", 64'(fpi_req_tag), 64'd0);
    respond(2'd0, 32'h40400000, 5'd0);
    chk("single_wb_latency", 64'(wb_valid), 64'd1);
    chk("single_wb_dst", 64'(wb_dst), 64'd3);
    idle(3);

    // out of order
    do_reset();
    issue(4'd2, 32'h1, 32'h2, 5'd1, 2'd0, 32'h11, 5'd0);
    issue(4'd3, 32'h3, 32'h4, 5'd2, 2'd1, 32'h22, 5'd0);
    issue(4'd4, 32'h5, 32'h6, 5'd3, 2'd2, 32'h33, 5'h01);
    respond(2'd2, 32'h33, 5'h01);
    chk("ooo_no_early_wb", 64'(wb_valid), 64'd0);
    respond(2'd0, 32'h11, 5'd0);
    respond(2'd1, 32'h22, 5'd0);
    idle(4);
    chk("ooo_drained_busy", 64'(busy), 64'd0);

    // full ROB, wb backpressure, wrap
    do_reset();
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(4'd5, 32'(i), 32'(i + 10), 5'(4 + i), 2'(i),
            32'hA0 + 32'(i), 5'd0);
    end
    @(negedge clk);
    chk("full_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    respond(2'd0, 32'hA0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wbstall_valid", 64'(wb_valid), 64'd1);
      chk("wbstall_dst", 64'(wb_dst), 64'd4);
      chk("wbstall_data", 64'(wb_data), 64'hA0);
      chk("wbstall_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    tick();
    wb_ready = 1'b1;
    @(negedge clk);
    chk("retire_cycle_cmd_ready", 64'(cmd_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("after_retire_cmd_ready", 64'(cmd_ready), 64'd1);
    tick();
    issue(4'd6, 32'h77, 32'h88, 5'd8, 2'd0, 32'hA4, 5'h10);
    respond(2'd1, 32'hA1, 5'd0);
    respond(2'd2, 32'hA2, 5'd0);
    respond(2'd3, 32'hA3, 5'd0);
    respond(2'd0, 32'hA4, 5'h10);
    idle(4);

    // request backpressure
    do_reset();
    fpi_req_ready = 1'b0;
    issue(4'd7, 32'hCAFE, 32'hBEEF, 5'd9, 2'd0, 32'h55, 5'd0);
    fork
      issue(4'd8, 32'h1234, 32'h5678, 5'd10, 2'd1, 32'h66, 5'd0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("reqstall_op", 64'(fpi_req_op), 64'd7);
          chk("reqstall_a", 64'(fpi_req_a), 64'hCAFE);
          chk("reqstall_tag", 64'(fpi_req_tag), 64'd0);
          chk("reqstall_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        tick();
        fpi_req_ready = 1'b1;
      end
    join
    respond(2'd1, 32'h66, 5'd0);
    respond(2'd0, 32'h55, 5'd0);
    idle(4);

    // stray response
    respond(2'd2, 32'hDEAD, 5'd0);
    chk("stray_err_tag", 64'(err_tag), 64'd1);
    chk("stray_wb_valid", 64'(wb_valid), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    idle(2);
    chk("stray_sticky", 64'(err_tag), 64'd1);

    // reset with ops outstanding
    issue(4'd9, 32'h1, 32'h1, 5'd1, 2'd2, 32'h0, 5'd0);
    issue(4'd9, 32'h2, 32'h2, 5'd2, 2'd3, 32'h0, 5'd0);
    issue(4'd9, 32'h3, 32'h3, 5'd3, 2'd0, 32'h0, 5'd0);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    do_reset();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("midrst_err_tag", 64'(err_tag), 64'd0);
    issue(4'd1, 32'h40000000, 32'h40000000, 5'd12, 2'd0,
          32'h40800000, 5'd0);
    respond(2'd0, 32'h40800000, 5'd0);
    idle(4);

    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    chk("wb_q_empty", 64'(wb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
